// File: rtl/mux4_arb_pkg.sv
// rtl/mux4_arb_pkg.sv - shared constants, state type and pointer helper for mux4_rr_arbiter
package mux4_arb_pkg;

  localparam int DEF_W = 4;
  localparam int CNT_W = 8;

  // Bus occupancy; the encoding is the out_valid bit itself.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  // Explicit wrap so non-power-of-2 requester counts never rely on modulo.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_vld
);

  localparam int PW = $clog2(NREQ);

  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && req_valid[idx[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving one registered shared bus
// Optional per-requester grant counters via MUX4_RR_ARBITER_STATS_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DEF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  output logic [W-1:0]            out_data,
  output logic [$clog2(NREQ)-1:0] out_src,
  input  logic                    out_ready
`ifdef MUX4_RR_ARBITER_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]   grant_cnt
`endif
);

  localparam int PW = $clog2(NREQ);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          grant_vld;
  logic          load_en;
  logic          xfer_in;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_valid(req_valid),
    .ptr      (ptr),
    .grant_idx(grant_idx),
    .grant_vld(grant_vld)
  );

  assign load_en = (state == ST_EMPTY) || out_ready;
  // rst gates the accept so a requester never sees a strobe that gets discarded.
  assign xfer_in = grant_vld && load_en && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (xfer_in) state_nxt = ST_FULL;
      ST_FULL: begin
        if (xfer_in) begin
          state_nxt = ST_FULL;
        end else if (out_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_FULL);
    req_ready = '0;
    if (xfer_in) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (xfer_in) begin
      out_data <= req_data[grant_idx*W +: W];
      out_src  <= grant_idx;
      ptr      <= PW'(wrap_inc(int'(grant_idx), NREQ));
    end
  end

`ifdef MUX4_RR_ARBITER_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (req_ready[i] && req_valid[i] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - randomized and directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [1:0]        out_src;
  logic              out_ready;
`ifdef MUX4_RR_ARBITER_STATS_EN
  logic [NREQ*8-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  logic [3:0] m_data;
  int         m_src;
  int         m_cnt[NREQ];

  mux4_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready)
`ifdef MUX4_RR_ARBITER_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int g;
    g = model_grant();
    if (rst || g < 0 || (m_valid && !out_ready)) return '0;
    return NREQ'(1) << g;
  endfunction

  function automatic void model_edge();
    int g;
    g = model_grant();
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else if ((!m_valid || out_ready) && g >= 0) begin
      m_data  = req_data[g*W +: W];
      m_src   = g;
      m_valid = 1;
      m_ptr   = (g + 1) % NREQ;
      if (m_cnt[g] < 255) m_cnt[g] = m_cnt[g] + 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    req_valid = 4'b0010;
    req_data  = 16'h00A0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_mid got %b exp 0000", req_ready); end
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle got v=%b d=%h r=%b exp v=0 d=0 r=0", out_valid, out_data, req_ready);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_src !== 2'd0) begin errors++; $display("FAIL idle_after_reset got v=%b s=%0d exp v=0 s=0", out_valid, out_src); end
  endtask

  task automatic test_single();
    do_reset(1);
    out_ready = 1'b1;
    req_valid = 4'b0001;
    req_data  = 16'h000F;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hF || out_src !== 2'd0) begin
      errors++; $display("FAIL single_bus got v=%b d=%h s=%0d exp v=1 d=f s=0", out_valid, out_data, out_src);
    end
    req_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'hF) begin errors++; $display("FAIL single_drain got v=%b d=%h exp v=0 d=f", out_valid, out_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_d [5];
    int         exp_s [5];
    exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    exp_s = '{0, 1, 2, 3, 0};
    do_reset(1);
    out_ready = 1'b1;
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[c] || out_src !== 2'(exp_s[c])) begin
        errors++;
        $display("FAIL rr_seq[%0d] got v=%b d=%h s=%0d exp v=1 d=%h s=%0d", c, out_valid, out_data, out_src, exp_d[c], exp_s[c]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] d2;
    do_reset(1);
    out_ready = 1'b1;
    req_valid = 4'b0010;
    req_data  = 16'h0010;
    tick();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      req_data = 16'($urandom);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", c, req_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h1 || out_src !== 2'd1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d exp v=1 d=1 s=1", c, out_valid, out_data, out_src);
      end
    end
    out_ready = 1'b1;
    d2 = req_data[11:8];
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", req_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== d2 || out_src !== 2'd2) begin
      errors++; $display("FAIL bp_release_bus got v=%b d=%h s=%0d exp v=1 d=%h s=2", out_valid, out_data, out_src, d2);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_wrap_skip();
    logic [NREQ-1:0] exp_r [3];
    exp_r = '{4'b0001, 4'b0100, 4'b0001};
    do_reset(1);
    out_ready = 1'b1;
    req_valid = 4'b0100;
    req_data  = 16'h0500;
    tick();
    req_valid = 4'b0101;
    req_data  = 16'h0706;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_r[c]) begin errors++; $display("FAIL wrap_ready[%0d] got %b exp %b", c, req_ready, exp_r[c]); end
      tick();
      checks++;
      if (out_src !== (c == 1 ? 2'd2 : 2'd0)) begin
        errors++; $display("FAIL wrap_src[%0d] got %0d exp %0d", c, out_src, (c == 1 ? 2 : 0));
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] er;
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      req_valid = 4'($urandom);
      req_data  = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      er = model_ready();
      checks++;
      if (req_ready !== er) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", c, req_ready, er); end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_src !== 2'(m_src)) begin
        errors++;
        $display("FAIL rand_bus[%0d] got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", c, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
`ifdef MUX4_RR_ARBITER_STATS_EN
      for (int i = 0; i < NREQ; i++) begin
        checks++;
        if (grant_cnt[i*8 +: 8] !== 8'(m_cnt[i])) begin
          errors++; $display("FAIL rand_cnt[%0d][%0d] got %0d exp %0d", c, i, grant_cnt[i*8 +: 8], m_cnt[i]);
        end
      end
`endif
    end
    rst = 1'b0;
    req_valid = '0;
    tick();
  endtask

`ifdef MUX4_RR_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset(1);
    out_ready = 1'b1;
    req_valid = 4'b0001;
    req_data  = 16'h0003;
    repeat (300) tick();
    checks++;
    if (grant_cnt !== 32'h0000_00FF) begin errors++; $display("FAIL stats_sat got %h exp 000000ff", grant_cnt); end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL stats_rst_ready got %b exp 0000", req_ready); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b0 || grant_cnt !== 32'h0) begin
      errors++; $display("FAIL stats_rst got v=%b cnt=%h exp v=0 cnt=0", out_valid, grant_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b0;
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_random();
`ifdef MUX4_RR_ARBITER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
